seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexing controller for the on-board multi-digit seven-segment display. Accepts a complete frame of per-digit segment patterns (the adder_AXI m_data format) over an AXI-stream-style valid/ready handshake. Drives one digit at a time through anode selects and a shared cathode bus. New frames are swapped in only at frame boundaries, so the display never tears.

Parameters:
N_DIGITS, 2, number of multiplexed digits (>=1).
REFRESH_DIV, 100000, clock cycles per digit slot (>=2).
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV, may be 0.
ACTIVE_LOW, 1, 1 = anodes and segments driven active-low; 0 = active-high.

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
s_valid  input  1  frame valid
s_ready  output  1  controller can accept a frame
s_data  input  [N_DIGITS-1:0][6:0]  per-digit patterns, bit=1 means segment lit, index 0 = rightmost digit
an  output  N_DIGITS  anode enables (polarity per ACTIVE_LOW)
seg  output  7  cathode pattern for the active digit (polarity per ACTIVE_LOW)
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Single clock domain. Reset is synchronous, active-low, and takes priority over all other activity.
- Reset values:
  - an = all digits off; seg = all segments off (all-1 if ACTIVE_LOW).
  - s_ready = 1; frame_done = 0.
  - Display and pending registers cleared to blank; slot counter = 0; digit index = 0; pending flag = 0.
- Slot timer:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index advances (N_DIGITS-1 wraps to 0).
- Per-slot FSM, re-entered every slot:
  - BLANK while cnt < BLANK_CYCLES: an all off, seg blank.
  - DRIVE otherwise: an selects the current digit only; seg = display[digit].
  - BLANK_CYCLES=0 means DRIVE for the whole slot.
- Outputs an/seg are registered: they reflect the cnt/digit/FSM state of the previous cycle (1-cycle latency). Polarity inversion is applied at the output register.
- Input buffer (one-deep pending register):
  - s_ready = !pend_valid.
  - On s_valid && s_ready: capture s_data into pend, set pend_valid.
  - While s_ready = 0, s_data/s_valid are ignored. The upstream holds s_data stable while valid.
- Frame boundary is cnt == REFRESH_DIV-1 && digit == N_DIGITS-1. At the boundary:
  - frame_done pulses high the following cycle.
  - If pend_valid: display <= pend, pend_valid cleared, s_ready = 1 next cycle.
  - If no pending frame: display is retained unchanged indefinitely.
- Simultaneous accept and boundary with pend empty: the word goes to pend and is NOT displayed until the next boundary. There is no bypass.
- Boundary with pend full and s_valid high: the transfer completes, pend empties, and s_ready rises the next cycle. A new frame is accepted from then on.
- Reset mid-scan or with a pending frame: everything returns to reset values and the pending frame is discarded.
- Refresh rate = f_clk / (REFRESH_DIV × N_DIGITS). The default at 100 MHz is 500 Hz per frame.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t = logic [6:0].
  - constant SEG_BLANK = 7'b0.
  - function apply_pol(value, active_low) used for an/seg.
- Sub-module seg7_scan_timer (REFRESH_DIV, N_DIGITS, BLANK_CYCLES) outputs cnt-derived blank flag, digit index, and frame_boundary strobe.
- Handshake, pending/display registers and output registers live in seg7_scan_ctrl.

Test Plan:
All scenarios use N_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
1. Reset: hold rstn=0 for 3 cycles -> an=2'b11, seg=7'h7F, s_ready=1, frame_done=0; release -> first slot blank for 2 cycles, then digit 0 driven with seg=7'h7F (blank frame).
2. Load frame: send s_data={7'h06,7'h3F} for one cycle -> s_ready drops next cycle. After the next boundary: slot 0 shows an=2'b10, seg=~7'h3F=7'h40; slot 1 shows an=2'b01, seg=~7'h06=7'h79. Each slot has 2 blank cycles then 6 drive cycles. frame_done pulses every 16 cycles.
3. Backpressure: send frame A then frame B with s_valid held high -> B is not accepted until the cycle after A's boundary transfer. Displayed sequence is A for one full frame, then B. No frame is lost or repeated.
4. Coincident accept at boundary: assert s_valid with pend empty exactly on the boundary cycle -> frame captured into pend, display unchanged for the following frame, new pattern visible only after the next boundary (16 cycles later).
5. Reset mid-operation: assert rstn=0 during DRIVE of digit 1 with a pending frame -> next cycle an=2'b11, seg=7'h7F, s_ready=1. The pending frame is never displayed.
6. Variant BLANK_CYCLES=0, ACTIVE_LOW=0: frame {7'h5B,7'h4F} -> an=2'b01 with seg=7'h4F for all 8 cycles, then an=2'b10 with seg=7'h5B. an is never all-zero after the first frame boundary.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Pattern with every segment unlit (logical sense, before polarity).
    localparam seg_t SEG_BLANK = 7'b0;

    // Converts a logical "1 = on" vector to pin polarity.
    // Callers zero-extend into and slice out of the 32-bit container.
    function automatic logic [31:0] apply_pol(input logic [31:0] value, input bit active_low);
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer: counts cycles within a digit slot, steps the digit index,
// and flags the anti-ghosting blank window and the frame boundary.
module seg7_scan_timer #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned BLANK_CYCLES = 4,
    localparam int unsigned CNT_W       = $clog2(REFRESH_DIV),
    localparam int unsigned DIG_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             blank,
    output logic [DIG_W-1:0] digit,
    output logic             frame_boundary
);

    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
    logic             digit_last;

    assign cnt_wrap       = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign digit_last     = (digit == DIG_W'(N_DIGITS - 1));
    assign frame_boundary = cnt_wrap && digit_last;

    // A zero-length blank window means the whole slot is driven.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank = 1'b0;
    end else begin : g_blank
        assign blank = (cnt < CNT_W'(BLANK_CYCLES));
    end

    // Slot counter and digit index; the digit steps when the slot wraps.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt   <= '0;
            digit <= '0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            if (cnt_wrap) begin
                digit <= digit_last ? '0 : digit + DIG_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment display controller. Frames arrive over a
// valid/ready handshake into a one-deep pending buffer and are swapped into
// the display register only at frame boundaries so the display never tears.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter bit          ACTIVE_LOW   = 1'b1,
    localparam int unsigned DIG_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [N_DIGITS-1:0][6:0] s_data,
    output logic [N_DIGITS-1:0]      an,
    output logic [6:0]               seg,
    output logic                     frame_done
);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [N_DIGITS-1:0] AN_OFF  = N_DIGITS'(apply_pol(32'd0, ACTIVE_LOW));
    localparam seg_t                SEG_OFF = seg_t'(apply_pol(32'(SEG_BLANK), ACTIVE_LOW));

    logic             blank;
    logic [DIG_W-1:0] digit;
    logic             frame_boundary;
    logic [0:0]       slot_state;

    seg7_scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .N_DIGITS     (N_DIGITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rstn           (rstn),
        .blank          (blank),
        .digit          (digit),
        .frame_boundary (frame_boundary)
    );

    seg_t [N_DIGITS-1:0] pend_q;
    seg_t [N_DIGITS-1:0] display_q;
    logic                pend_valid_q;
    logic [N_DIGITS-1:0] an_d;
    seg_t                seg_d;
    logic [N_DIGITS-1:0] an_raw;
    seg_t                seg_raw;

    assign s_ready = !pend_valid_q;

    // Per-slot state is a pure function of the slot counter, re-entered every slot.
    always_comb begin
        slot_state = blank ? ST_BLANK : ST_DRIVE;
    end

    // Next output values in logical sense, then converted to pin polarity.
    always_comb begin
        an_raw  = '0;
        seg_raw = SEG_BLANK;
        if (slot_state == ST_DRIVE) begin
            an_raw[digit] = 1'b1;
            seg_raw       = display_q[digit];
        end
        an_d  = N_DIGITS'(apply_pol(32'(an_raw), ACTIVE_LOW));
        seg_d = seg_t'(apply_pol(32'(seg_raw), ACTIVE_LOW));
    end

    // Pending buffer and display swap. A boundary with a full buffer always
    // drains it; an accept can only happen while the buffer is empty, so a
    // coincident accept lands in pend and waits for the next boundary.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q       <= '{default: SEG_BLANK};
            display_q    <= '{default: SEG_BLANK};
            pend_valid_q <= 1'b0;
        end else if (frame_boundary && pend_valid_q) begin
            display_q    <= pend_q;
            pend_valid_q <= 1'b0;
        end else if (s_valid && !pend_valid_q) begin
            pend_q       <= s_data;
            pend_valid_q <= 1'b1;
        end
    end

    // Registered pin drivers and the frame pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= frame_boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: main instance N=2, DIV=8, BLANK=2,
// active-low, plus a BLANK=0 active-high variant.
module tb_seg7_scan_ctrl;

    logic            clk;
    logic            rstn;
    logic            s_valid;
    logic            s_ready;
    logic [1:0][6:0] s_data;
    logic [1:0]      an;
    logic [6:0]      seg;
    logic            frame_done;

    logic            rstn2;
    logic            s_valid2;
    logic            s_ready2;
    logic [1:0][6:0] s_data2;
    logic [1:0]      an2;
    logic [6:0]      seg2;
    logic            frame_done2;

    int total;
    int bad;
    int pos;

    seg7_scan_ctrl #(
        .N_DIGITS     (2),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    seg7_scan_ctrl #(
        .N_DIGITS     (2),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (0),
        .ACTIVE_LOW   (1'b0)
    ) dut2 (
        .clk        (clk),
        .rstn       (rstn2),
        .s_valid    (s_valid2),
        .s_ready    (s_ready2),
        .s_data     (s_data2),
        .an         (an2),
        .seg        (seg2),
        .frame_done (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; everything after it happens 1 time unit past the edge.
    // pos counts edges since the last reset release, so the outputs now
    // reflect timer position p = pos-1 (cnt = p%8, digit = (p/8)%2).
    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic run_to(input int target);
        while (pos < target) tick();
    endtask

    initial begin
        int p;
        int c;
        int d;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;

        total    = 0;
        bad      = 0;
        pos      = 0;
        rstn     = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        rstn2    = 1'b0;
        s_valid2 = 1'b0;
        s_data2  = '0;

        // 1. Reset state, then a blank frame after release.
        repeat (3) tick();
        check("rst_an", 32'(an), 32'h3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ready", 32'(s_ready), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst2_an", 32'(an2), 32'h0);
        check("rst2_seg", 32'(seg2), 32'h0);
        rstn = 1'b1;
        pos  = 0;
        tick();
        check("boot_blank1_an", 32'(an), 32'h3);
        tick();
        check("boot_blank2_an", 32'(an), 32'h3);
        tick();
        check("boot_drive_an", 32'(an), 32'h2);
        check("boot_drive_seg", 32'(seg), 32'h7F);

        // 2. Load a frame; it appears only after the first boundary.
        s_valid = 1'b1;
        s_data  = {7'h06, 7'h3F};
        tick();
        s_valid = 1'b0;
        check("load_ready_low", 32'(s_ready), 32'h0);
        run_to(11);
        check("pre_swap_an", 32'(an), 32'h1);
        check("pre_swap_seg", 32'(seg), 32'h7F);
        run_to(15);
        check("pre_fd", 32'(frame_done), 32'h0);
        tick();
        check("fd_16", 32'(frame_done), 32'h1);
        check("ready_after_swap", 32'(s_ready), 32'h1);
        for (int k = 17; k <= 32; k++) begin
            tick();
            p = k - 1;
            c = p % 8;
            d = (p / 8) % 2;
            exp_an  = (c < 2) ? 2'b11 : ((d == 0) ? 2'b10 : 2'b01);
            exp_seg = (c < 2) ? 7'h7F : ((d == 0) ? 7'h40 : 7'h79);
            check($sformatf("frame1_an_t%0d", k), 32'(an), 32'(exp_an));
            check($sformatf("frame1_seg_t%0d", k), 32'(seg), 32'(exp_seg));
            if (k == 17 || k == 31 || k == 32) begin
                check($sformatf("frame1_fd_t%0d", k), 32'(frame_done), (k == 32) ? 32'h1 : 32'h0);
            end
        end

        // 3. Backpressure: A accepted, B held until A is swapped in.
        s_valid = 1'b1;
        s_data  = {7'h66, 7'h6D};
        tick();
        s_data = {7'h7D, 7'h07};
        run_to(40);
        check("bp_ready_low", 32'(s_ready), 32'h0);
        run_to(48);
        check("bp_ready_rise", 32'(s_ready), 32'h1);
        check("bp_fd", 32'(frame_done), 32'h1);
        tick();
        s_valid = 1'b0;
        check("bp_b_taken", 32'(s_ready), 32'h0);
        run_to(51);
        check("bp_a_d0_an", 32'(an), 32'h2);
        check("bp_a_d0_seg", 32'(seg), 32'h12);
        run_to(59);
        check("bp_a_d1_an", 32'(an), 32'h1);
        check("bp_a_d1_seg", 32'(seg), 32'h19);
        run_to(67);
        check("bp_b_d0_seg", 32'(seg), 32'h78);
        run_to(75);
        check("bp_b_d1_seg", 32'(seg), 32'h02);
        run_to(83);
        check("retain_b_d0_seg", 32'(seg), 32'h78);
        check("retain_ready", 32'(s_ready), 32'h1);

        // 4. Accept on the boundary cycle (p=95): goes to pend, not displayed.
        run_to(95);
        s_valid = 1'b1;
        s_data  = {7'h39, 7'h5E};
        tick();
        s_valid = 1'b0;
        check("coin_ready", 32'(s_ready), 32'h0);
        check("coin_fd", 32'(frame_done), 32'h1);
        run_to(99);
        check("coin_old_an", 32'(an), 32'h2);
        check("coin_old_seg", 32'(seg), 32'h78);
        run_to(107);
        check("coin_old_d1_seg", 32'(seg), 32'h02);
        run_to(115);
        check("coin_new_d0_seg", 32'(seg), 32'h21);
        run_to(123);
        check("coin_new_d1_an", 32'(an), 32'h1);
        check("coin_new_d1_seg", 32'(seg), 32'h46);

        // 5. Reset while digit 1 is driven and a frame is pending.
        s_valid = 1'b1;
        s_data  = {7'h7F, 7'h7F};
        tick();
        s_valid = 1'b0;
        check("mid_pend_ready", 32'(s_ready), 32'h0);
        check("mid_pre_an", 32'(an), 32'h1);
        rstn = 1'b0;
        tick();
        check("mid_rst_an", 32'(an), 32'h3);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_ready", 32'(s_ready), 32'h1);
        check("mid_rst_fd", 32'(frame_done), 32'h0);
        tick();
        rstn = 1'b1;
        pos  = 0;
        run_to(3);
        check("post_rst_an", 32'(an), 32'h2);
        check("post_rst_seg", 32'(seg), 32'h7F);
        run_to(19);
        check("discard_an", 32'(an), 32'h2);
        check("discard_seg", 32'(seg), 32'h7F);

        // 6. Variant: no blank window, active-high pins.
        rstn2    = 1'b1;
        s_valid2 = 1'b1;
        s_data2  = {7'h5B, 7'h4F};
        pos      = 0;
        tick();
        s_valid2 = 1'b0;
        check("v_first_an", 32'(an2), 32'h1);
        check("v_first_seg", 32'(seg2), 32'h0);
        run_to(16);
        check("v_fd", 32'(frame_done2), 32'h1);
        for (int k = 17; k <= 32; k++) begin
            tick();
            exp_an  = (k <= 24) ? 2'b01 : 2'b10;
            exp_seg = (k <= 24) ? 7'h4F : 7'h5B;
            check($sformatf("v_an_t%0d", k), 32'(an2), 32'(exp_an));
            check($sformatf("v_seg_t%0d", k), 32'(seg2), 32'(exp_seg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
